// File: rtl/ro_pkg.sv
// ro_pkg -- shared types and default constants for the ring-oscillator
// sample controller.
//
// Contents:
//   RO_NUM_SAMPLE_WIDTH  default width of the sample-count / window-length fields
//   RO_PIPELINE_LATENCY  default cycles from window strobe to a valid adder-tree sum
//   ro_ctrl_state_t      controller FSM state encoding
package ro_pkg;

    localparam int RO_NUM_SAMPLE_WIDTH = 16;
    localparam int RO_PIPELINE_LATENCY = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } ro_ctrl_state_t;

endpackage

// File: rtl/ro_strobe_delay.sv
// ro_strobe_delay -- fixed-latency delay line for the window-end strobe.
// A strobe entering on strobe_in appears on strobe_out exactly LATENCY
// cycles later, lining up with the adder-tree result at the FIFO input.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset, flushes the line
//   strobe_in    window-end strobe from the controller
//   strobe_out   strobe delayed by LATENCY cycles
//   any_pending  a strobe is still in flight and will leave on a later cycle
module ro_strobe_delay #(
    parameter int LATENCY = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_in,
    output logic strobe_out,
    output logic any_pending
);

    logic [LATENCY-1:0] sr;

    // any_pending ignores the output stage: a strobe sitting there is
    // written this very cycle, so the drain logic may already move on.
    generate
        if (LATENCY == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr <= strobe_in;
                end
            end
            assign any_pending = 1'b0;
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[LATENCY-2:0], strobe_in};
                end
            end
            assign any_pending = |sr[LATENCY-2:0];
        end
    endgenerate

    assign strobe_out = sr[LATENCY-1];

endmodule

// File: rtl/ro_sample_ctrl.sv
// ro_sample_ctrl -- run controller for ring-oscillator sampling.
// A run is num_samples windows; each window is one CLEAR cycle (counter
// clear) followed by collect_cycles COLLECT cycles (counter enabled). The
// last COLLECT cycle emits a window strobe which, after PIPELINE_LATENCY
// cycles, becomes a FIFO write (or an overflow if the FIFO is full).
//
// Valid/ready: there is no back-pressure on results. fifo_wr_en is a
// one-cycle write request qualified by fifo_full; a result whose write
// cycle sees fifo_full=1 is lost and recorded in the sticky overflow flag.
//
// Ports:
//   clk, afu_rst_n           clock, synchronous active-low reset
//   go, stop                 start pulse (IDLE only), abort (CLEAR/COLLECT only)
//   num_samples              windows per run, latched at go
//   collect_cycles           enable cycles per window, latched at go (0 -> 1)
//   fifo_full                result FIFO full
//   ro_en, cnt_clr, cnt_en   oscillator enable, counter clear, counter enable
//   fifo_wr_en               result FIFO write strobe
//   busy, done               run in progress, one-cycle end-of-run pulse
//   overflow                 sticky: a result was dropped this run
//   samples_taken            windows completed in the current or last run
//   fsm_state                current controller state (debug visibility)
module ro_sample_ctrl
    import ro_pkg::*;
#(
    parameter int NUM_SAMPLE_WIDTH = RO_NUM_SAMPLE_WIDTH,
    parameter int PIPELINE_LATENCY = RO_PIPELINE_LATENCY
) (
    input  logic                        clk,
    input  logic                        afu_rst_n,
    input  logic                        go,
    input  logic                        stop,
    input  logic [NUM_SAMPLE_WIDTH-1:0] num_samples,
    input  logic [NUM_SAMPLE_WIDTH-1:0] collect_cycles,
    input  logic                        fifo_full,
    output logic                        ro_en,
    output logic                        cnt_clr,
    output logic                        cnt_en,
    output logic                        fifo_wr_en,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [NUM_SAMPLE_WIDTH-1:0] samples_taken,
    output ro_ctrl_state_t              fsm_state
);

    localparam logic [NUM_SAMPLE_WIDTH-1:0] ONE = {{(NUM_SAMPLE_WIDTH-1){1'b0}}, 1'b1};

    ro_ctrl_state_t              state;
    ro_ctrl_state_t              state_next;
    logic [NUM_SAMPLE_WIDTH-1:0] ns_lat;
    logic [NUM_SAMPLE_WIDTH-1:0] cc_lat;
    logic [NUM_SAMPLE_WIDTH-1:0] cyc_cnt;
    logic [NUM_SAMPLE_WIDTH-1:0] samples_q;
    logic                        overflow_q;
    logic                        go_accept;
    logic                        win_last;
    logic                        window_strobe;
    logic                        delayed_strobe;
    logic                        any_pending;

    // cyc_cnt runs 0 .. cc_lat-1 inside COLLECT, so the full 16-bit range
    // of cc_lat is usable without the counter wrapping.
    assign win_last = (cyc_cnt == (cc_lat - ONE));

    always_comb begin
        state_next    = state;
        ro_en         = 1'b0;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        go_accept     = 1'b0;
        window_strobe = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    go_accept  = 1'b1;
                    state_next = (num_samples == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                ro_en      = 1'b1;
                cnt_clr    = 1'b1;
                state_next = stop ? ST_DRAIN : ST_COLLECT;
            end
            ST_COLLECT: begin
                ro_en  = 1'b1;
                cnt_en = 1'b1;
                if (stop) begin
                    // An abort on the last cycle discards that window.
                    state_next = ST_DRAIN;
                end else if (win_last) begin
                    window_strobe = 1'b1;
                    state_next    = ((samples_q + ONE) == ns_lat) ? ST_DRAIN : ST_CLEAR;
                end
            end
            ST_DRAIN: begin
                if (!any_pending) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!afu_rst_n) begin
            state      <= ST_IDLE;
            ns_lat     <= '0;
            cc_lat     <= ONE;
            cyc_cnt    <= '0;
            samples_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;

            if (go_accept) begin
                ns_lat <= num_samples;
                cc_lat <= (collect_cycles == '0) ? ONE : collect_cycles;
            end

            if (state == ST_CLEAR) begin
                cyc_cnt <= '0;
            end else if (state == ST_COLLECT) begin
                cyc_cnt <= cyc_cnt + ONE;
            end

            if (go_accept) begin
                samples_q <= '0;
            end else if (window_strobe) begin
                samples_q <= samples_q + ONE;
            end

            // go is only accepted in IDLE, when the delay line is already
            // empty, so clearing and setting can never collide.
            if (go_accept) begin
                overflow_q <= 1'b0;
            end else if (delayed_strobe && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    ro_strobe_delay #(
        .LATENCY (PIPELINE_LATENCY)
    ) u_strobe_delay (
        .clk         (clk),
        .rst_n       (afu_rst_n),
        .strobe_in   (window_strobe),
        .strobe_out  (delayed_strobe),
        .any_pending (any_pending)
    );

    assign fifo_wr_en    = delayed_strobe & ~fifo_full;
    assign overflow      = overflow_q;
    assign samples_taken = samples_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// tb_ro_sample_ctrl -- directed, table-driven bench for ro_sample_ctrl.
// Each table row is one 32-cycle scenario: input events by cycle number
// (go at cycle 0) and hand-written per-cycle masks of the expected outputs.
// A hand-written sequence covers the 0xFFFF window length.
module tb_ro_sample_ctrl;
    import ro_pkg::*;

    localparam int W = 16;
    localparam int NCYC = 32;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           afu_rst_n;
    logic           go;
    logic           stop;
    logic [W-1:0]   num_samples;
    logic [W-1:0]   collect_cycles;
    logic           fifo_full;
    logic           ro_en;
    logic           cnt_clr;
    logic           cnt_en;
    logic           fifo_wr_en;
    logic           busy;
    logic           done;
    logic           overflow;
    logic [W-1:0]   samples_taken;
    ro_ctrl_state_t fsm_state;

    ro_sample_ctrl #(
        .NUM_SAMPLE_WIDTH (W),
        .PIPELINE_LATENCY (5)
    ) dut (
        .clk            (clk),
        .afu_rst_n      (afu_rst_n),
        .go             (go),
        .stop           (stop),
        .num_samples    (num_samples),
        .collect_cycles (collect_cycles),
        .fifo_full      (fifo_full),
        .ro_en          (ro_en),
        .cnt_clr        (cnt_clr),
        .cnt_en         (cnt_en),
        .fifo_wr_en     (fifo_wr_en),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .samples_taken  (samples_taken),
        .fsm_state      (fsm_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- vector table ----------------
    typedef struct {
        int          id;
        logic [W-1:0] ns;
        logic [W-1:0] cc;
        int          stop_cyc;
        int          full_cyc;
        int          rst_cyc;
        logic [31:0] go_extra;
        int          chg_from;
        bit          skip_reset;
        logic [31:0] m_ro;
        logic [31:0] m_clr;
        logic [31:0] m_en;
        logic [31:0] m_wr;
        logic [31:0] m_busy;
        logic [31:0] m_done;
        logic [31:0] m_ovf;
        logic [W-1:0] exp_st;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] at(input int c);
        return rng(c, c);
    endfunction

    // Basic run: ns=3, cc=4, latency 5, go at cycle 0.
    function automatic vec_t base_run(input int id);
        vec_t v;
        v.id         = id;
        v.ns         = 16'd3;
        v.cc         = 16'd4;
        v.stop_cyc   = -1;
        v.full_cyc   = -1;
        v.rst_cyc    = -1;
        v.go_extra   = '0;
        v.chg_from   = -1;
        v.skip_reset = 1'b0;
        v.m_ro       = rng(1, 15);
        v.m_clr      = at(1) | at(6) | at(11);
        v.m_en       = rng(2, 5) | rng(7, 10) | rng(12, 15);
        v.m_wr       = at(10) | at(15) | at(20);
        v.m_busy     = rng(1, 21);
        v.m_done     = at(21);
        v.m_ovf      = '0;
        v.exp_st     = 16'd3;
        return v;
    endfunction

    task automatic build_table();
        vec_t v;
        // 0: basic run
        tbl.push_back(base_run(0));
        // 1: zero samples -> straight to DONE
        v = base_run(1);
        v.ns = 16'd0; v.m_ro = '0; v.m_clr = '0; v.m_en = '0; v.m_wr = '0;
        v.m_busy = at(1); v.m_done = at(1); v.exp_st = 16'd0;
        tbl.push_back(v);
        // 2: stop during COLLECT of window 2
        v = base_run(2);
        v.stop_cyc = 8; v.m_ro = rng(1, 8); v.m_clr = at(1) | at(6);
        v.m_en = rng(2, 5) | rng(7, 8); v.m_wr = at(10);
        v.m_busy = rng(1, 11); v.m_done = at(11); v.exp_st = 16'd1;
        tbl.push_back(v);
        // 3: fifo full on the second write -> dropped, overflow sticky
        v = base_run(3);
        v.full_cyc = 15; v.m_wr = at(10) | at(20); v.m_ovf = rng(16, 31);
        tbl.push_back(v);
        // 4: no reset in between: go clears overflow; stop in DRAIN ignored
        v = base_run(4);
        v.skip_reset = 1'b1; v.stop_cyc = 18; v.m_ovf = at(0);
        tbl.push_back(v);
        // 5: reset mid-run at cycle 12
        v = base_run(5);
        v.rst_cyc = 12; v.m_ro = rng(1, 12); v.m_en = rng(2, 5) | rng(7, 10) | at(12);
        v.m_wr = at(10); v.m_busy = rng(1, 12); v.m_done = '0; v.exp_st = 16'd0;
        tbl.push_back(v);
        // 6: go pulses and parameter changes while busy -> same schedule
        v = base_run(6);
        v.go_extra = at(7) | at(12); v.chg_from = 1;
        tbl.push_back(v);
        // 7: collect_cycles=0 treated as 1
        v = base_run(7);
        v.ns = 16'd2; v.cc = 16'd0; v.m_ro = rng(1, 4); v.m_clr = at(1) | at(3);
        v.m_en = at(2) | at(4); v.m_wr = at(7) | at(9);
        v.m_busy = rng(1, 10); v.m_done = at(10); v.exp_st = 16'd2;
        tbl.push_back(v);
        // 8: stop in CLEAR
        v = base_run(8);
        v.stop_cyc = 6; v.m_ro = rng(1, 6); v.m_clr = at(1) | at(6);
        v.m_en = rng(2, 5); v.m_wr = at(10);
        v.m_busy = rng(1, 11); v.m_done = at(11); v.exp_st = 16'd1;
        tbl.push_back(v);
        // 9: stop on the last COLLECT cycle suppresses that window
        v = base_run(9);
        v.stop_cyc = 5; v.m_ro = rng(1, 5); v.m_clr = at(1);
        v.m_en = rng(2, 5); v.m_wr = '0;
        v.m_busy = rng(1, 7); v.m_done = at(7); v.exp_st = 16'd0;
        tbl.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    // Entry/exit point of every task: 1 time unit after a rising edge.
    task automatic do_reset();
        afu_rst_n      = 1'b0;
        go             = 1'b0;
        stop           = 1'b0;
        fifo_full      = 1'b0;
        num_samples    = '0;
        collect_cycles = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ro_en, cnt_clr, cnt_en, fifo_wr_en, busy, done, overflow} != 7'b0
            || samples_taken != '0 || fsm_state != ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got outs=%b st=%0d state=%0d, expected outs=0 st=0 state=IDLE",
                     {ro_en, cnt_clr, cnt_en, fifo_wr_en, busy, done, overflow},
                     samples_taken, fsm_state);
        end
        @(posedge clk);
        #1;
        afu_rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [6:0] got;
        logic [6:0] exp;
        if (!v.skip_reset) do_reset();
        for (int c = 0; c < NCYC; c++) begin
            go        = (c == 0) || v.go_extra[c];
            stop      = (c == v.stop_cyc);
            fifo_full = (c == v.full_cyc);
            afu_rst_n = (c != v.rst_cyc);
            if (v.chg_from >= 0 && c >= v.chg_from) begin
                num_samples    = 16'd1;
                collect_cycles = 16'd2;
            end else begin
                num_samples    = v.ns;
                collect_cycles = v.cc;
            end
            @(negedge clk);
            got = {ro_en, cnt_clr, cnt_en, fifo_wr_en, busy, done, overflow};
            exp = {v.m_ro[c], v.m_clr[c], v.m_en[c], v.m_wr[c],
                   v.m_busy[c], v.m_done[c], v.m_ovf[c]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec%0d_outputs cycle %0d: got {ro,clr,en,wr,busy,done,ovf}=%b expected %b",
                         v.id, c, got, exp);
            end
            @(posedge clk);
            #1;
        end
        go   = 1'b0;
        stop = 1'b0;
        n_checks++;
        if (samples_taken !== v.exp_st) begin
            n_fail++;
            $display("FAIL vec%0d_samples_taken: got %0d expected %0d", v.id, samples_taken, v.exp_st);
        end
    endtask

    // Longest window: 0xFFFF enable cycles, one sample.
    task automatic run_long_window();
        int en_cnt;
        int wr_cnt;
        int done_cyc;
        int c;
        do_reset();
        num_samples    = 16'd1;
        collect_cycles = 16'hFFFF;
        en_cnt   = 0;
        wr_cnt   = 0;
        done_cyc = -1;
        c        = 0;
        while (c < 70000 && done_cyc < 0) begin
            go = (c == 0);
            @(negedge clk);
            if (cnt_en) en_cnt++;
            if (fifo_wr_en) wr_cnt++;
            if (done) done_cyc = c;
            @(posedge clk);
            #1;
            c++;
        end
        go = 1'b0;
        n_checks++;
        if (done_cyc != 65542) begin
            n_fail++;
            $display("FAIL long_done_cycle: got %0d expected 65542 (-1 means timeout)", done_cyc);
        end
        n_checks++;
        if (en_cnt != 65535) begin
            n_fail++;
            $display("FAIL long_cnt_en_cycles: got %0d expected 65535", en_cnt);
        end
        n_checks++;
        if (wr_cnt != 1) begin
            n_fail++;
            $display("FAIL long_writes: got %0d expected 1", wr_cnt);
        end
        n_checks++;
        if (samples_taken !== 16'd1) begin
            n_fail++;
            $display("FAIL long_samples_taken: got %0d expected 1", samples_taken);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        afu_rst_n      = 1'b0;
        go             = 1'b0;
        stop           = 1'b0;
        fifo_full      = 1'b0;
        num_samples    = '0;
        collect_cycles = '0;
        @(posedge clk);
        #1;
        build_table();
        foreach (tbl[i]) begin
            run_vec(tbl[i]);
        end
        run_long_window();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
